serial_mem_sequencer: RTL and testbench

- Parametrised successor to the CPU's serial control FSM.
- Sequences instruction fetch, execute handshake, and load/store transfers over the serial link to the external (Arduino-side) memory.
- Generalised in data width, address width and lanes per beat, with per-beat flow control and an explicit command code for the external side.
- Sits between the instruction decoder/datapath shift registers and the serial link pins.

---
 rtl/serial_mem_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_serial_mem_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_mem_sequencer.sv
// ============================================================================
// serial_mem_sequencer
//   Fetch / execute / load / store sequencer for the serial memory link.
//   Optional build macro: SERIAL_MEM_SEQ_TIMEOUT_EN (wait-state watchdog).
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mem_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int LANE_W      = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       ard_receive_ready,
  input  logic       ard_data_ready,
  output logic       go,
  output logic       pc_shift_out,
  output logic       mar_shift_out,
  output logic       mdr_shift_out,
  output logic       mdr_shift_in,
  output logic       instr_shift_in,
  output logic       shift_done,
  output logic [1:0] mem_cmd,
  output logic       err
);

  localparam int AB   = ADDR_W / LANE_W;
  localparam int DB   = DATA_W / LANE_W;
  localparam int MAXB = (AB > DB) ? AB : DB;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  localparam logic [CW-1:0] AB_LAST = CW'(AB - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_FETCH = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_STORE = 2'b11;

  generate
    if ((DATA_W % LANE_W) != 0 || (ADDR_W % LANE_W) != 0) begin : g_bad_lane
      $error("serial_mem_sequencer: LANE_W must divide DATA_W and ADDR_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("serial_mem_sequencer: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  typedef enum logic [3:0] {
    F_ADDR = 4'd0,
    F_WAIT = 4'd1,
    F_DATA = 4'd2,
    EXEC   = 4'd3,
    L_ADDR = 4'd4,
    L_WAIT = 4'd5,
    L_DATA = 4'd6,
    S_ADDR = 4'd7,
    S_DATA = 4'd8,
    S_ACK  = 4'd9
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_a;
  logic          last_d;
  logic          timeout;

  assign last_a = (cnt == AB_LAST);
  assign last_d = (cnt == DB_LAST);

`ifdef SERIAL_MEM_SEQ_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  logic [WW-1:0] wd;
  logic          in_wait;

  assign in_wait = (state == F_WAIT) || (state == L_WAIT) || (state == S_ACK);
  assign timeout = in_wait && !ard_data_ready && (wd == WD_LAST);

  // Counts consecutive stalled wait cycles; any exit from waiting clears it.
  always_ff @(posedge clk) begin
    if (rst || !in_wait || ard_data_ready || timeout) begin
      wd <= '0;
    end else begin
      wd <= wd + WW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign err = timeout && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_ADDR;
      cnt   <= '0;
    end else begin
      case (state)
        F_ADDR: begin
          if (ard_receive_ready) begin
            if (last_a) begin
              state <= F_WAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        F_WAIT: begin
          if (ard_data_ready) begin
            state <= F_DATA;
          end else if (timeout) begin
            state <= F_ADDR;
          end
        end
        F_DATA: begin
          if (last_d) begin
            state <= EXEC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        EXEC: begin
          // Store takes priority when the decoder flags both.
          if (done) begin
            if (is_store) begin
              state <= S_ADDR;
            end else if (is_load) begin
              state <= L_ADDR;
            end else begin
              state <= F_ADDR;
            end
          end
        end
        L_ADDR: begin
          if (ard_receive_ready) begin
            if (last_a) begin
              state <= L_WAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        L_WAIT: begin
          if (ard_data_ready) begin
            state <= L_DATA;
          end else if (timeout) begin
            state <= F_ADDR;
          end
        end
        L_DATA: begin
          if (last_d) begin
            state <= F_ADDR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ADDR: begin
          if (ard_receive_ready) begin
            if (last_a) begin
              state <= S_DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_DATA: begin
          if (ard_receive_ready) begin
            if (last_d) begin
              state <= S_ACK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_ACK: begin
          if (ard_data_ready || timeout) begin
            state <= F_ADDR;
          end
        end
        default: begin
          state <= F_ADDR;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Out-shift strobes are gated by ard_receive_ready in the same cycle so a
  // stalled beat never reaches the shift registers.
  always_comb begin
    go             = 1'b0;
    pc_shift_out   = 1'b0;
    mar_shift_out  = 1'b0;
    mdr_shift_out  = 1'b0;
    mdr_shift_in   = 1'b0;
    instr_shift_in = 1'b0;
    shift_done     = 1'b0;
    mem_cmd        = CMD_IDLE;
    if (!rst) begin
      case (state)
        F_ADDR: begin
          mem_cmd      = CMD_FETCH;
          pc_shift_out = ard_receive_ready;
          shift_done   = ard_receive_ready && last_a;
        end
        F_WAIT: mem_cmd = CMD_FETCH;
        F_DATA: begin
          mem_cmd        = CMD_FETCH;
          instr_shift_in = 1'b1;
          shift_done     = last_d;
        end
        EXEC: go = !done;
        L_ADDR: begin
          mem_cmd       = CMD_LOAD;
          mar_shift_out = ard_receive_ready;
          shift_done    = ard_receive_ready && last_a;
        end
        L_WAIT: mem_cmd = CMD_LOAD;
        L_DATA: begin
          mem_cmd      = CMD_LOAD;
          mdr_shift_in = 1'b1;
          shift_done   = last_d;
        end
        S_ADDR: begin
          mem_cmd       = CMD_STORE;
          mar_shift_out = ard_receive_ready;
          shift_done    = ard_receive_ready && last_a;
        end
        S_DATA: begin
          mem_cmd       = CMD_STORE;
          mdr_shift_out = ard_receive_ready;
          shift_done    = ard_receive_ready && last_d;
        end
        S_ACK: mem_cmd = CMD_STORE;
        default: mem_cmd = CMD_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_mem_sequencer.sv
// ============================================================================
// tb_serial_mem_sequencer
//   Directed cycle-by-cycle bench: default instance plus a LANE_W=4 instance.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_mem_sequencer;

  logic clk;
  logic rst, done, is_load, is_store, rr, dr;

  logic a_go, a_pc, a_mar, a_mdro, a_mdri, a_ir, a_sd, a_err;
  logic [1:0] a_cmd;
  logic b_go, b_pc, b_mar, b_mdro, b_mdri, b_ir, b_sd, b_err;
  logic [1:0] b_cmd;
  logic [9:0] a_all, b_all;

  int n_assert = 0;
  int n_fail   = 0;
  int n_mdro   = 0;

  assign a_all = {a_go, a_pc, a_mar, a_mdro, a_mdri, a_ir, a_sd, a_cmd, a_err};
  assign b_all = {b_go, b_pc, b_mar, b_mdro, b_mdri, b_ir, b_sd, b_cmd, b_err};

  serial_mem_sequencer #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .done(done), .is_load(is_load), .is_store(is_store),
    .ard_receive_ready(rr), .ard_data_ready(dr),
    .go(a_go), .pc_shift_out(a_pc), .mar_shift_out(a_mar),
    .mdr_shift_out(a_mdro), .mdr_shift_in(a_mdri), .instr_shift_in(a_ir),
    .shift_done(a_sd), .mem_cmd(a_cmd), .err(a_err)
  );

  serial_mem_sequencer #(.LANE_W(4), .TIMEOUT_CYC(8)) dut4 (
    .clk(clk), .rst(rst), .done(done), .is_load(is_load), .is_store(is_store),
    .ard_receive_ready(rr), .ard_data_ready(dr),
    .go(b_go), .pc_shift_out(b_pc), .mar_shift_out(b_mar),
    .mdr_shift_out(b_mdro), .mdr_shift_in(b_mdri), .instr_shift_in(b_ir),
    .shift_done(b_sd), .mem_cmd(b_cmd), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges; rst stays high until the caller's first step.
  task automatic do_reset();
    rst = 1'b1; done = 1'b0; is_load = 1'b0; is_store = 1'b0; rr = 1'b1; dr = 1'b0;
    step();
    step();
    @(negedge clk);
    check_eq("rst_outs_a", 32'(a_all), 32'd0);
    check_eq("rst_outs_b", 32'(b_all), 32'd0);
  endtask

  // Runs the default instance through fetch so the next cycle is its EXEC.
  task automatic run_fetch();
    for (int t = 0; t < 33; t++) begin
      step();
      rst = 1'b0; rr = 1'b1; dr = 1'b1; done = 1'b0; is_load = 1'b0; is_store = 1'b0;
    end
  endtask

  initial begin
    // 1: default fetch with the response arriving at cycle 20
    do_reset();
    for (int t = 0; t < 42; t++) begin
      step();
      rst = 1'b0; rr = 1'b1; dr = (t >= 20); done = (t == 40);
      @(negedge clk);
      check_eq("t1_pc",   32'(a_pc), 32'(t <= 15 || t == 41));
      check_eq("t1_ir",   32'(a_ir), 32'(t >= 21 && t <= 36));
      check_eq("t1_sd",   32'(a_sd), 32'(t == 15 || t == 36));
      check_eq("t1_go",   32'(a_go), 32'(t >= 37 && t <= 39));
      check_eq("t1_cmd",  32'(a_cmd), (t <= 36 || t == 41) ? 32'd1 : 32'd0);
      check_eq("t1_ldst", 32'({a_mar, a_mdro, a_mdri, a_err}), 32'd0);
    end

    // 2: LANE_W=4 ALU instruction, done after three go cycles
    do_reset();
    for (int t = 0; t < 14; t++) begin
      step();
      rst = 1'b0; rr = 1'b1; dr = 1'b1; done = (t == 12);
      @(negedge clk);
      check_eq("t2_pc",   32'(b_pc), 32'(t <= 3 || t == 13));
      check_eq("t2_ir",   32'(b_ir), 32'(t >= 5 && t <= 8));
      check_eq("t2_sd",   32'(b_sd), 32'(t == 3 || t == 8));
      check_eq("t2_go",   32'(b_go), 32'(t >= 9 && t <= 11));
      check_eq("t2_cmd",  32'(b_cmd), (t <= 8 || t == 13) ? 32'd1 : 32'd0);
      check_eq("t2_ldst", 32'({b_mar, b_mdro, b_mdri}), 32'd0);
    end

    // 3: load with five stalled wait cycles
    do_reset();
    run_fetch();
    for (int t = 0; t < 40; t++) begin
      step();
      done = (t == 0); is_load = (t == 0); dr = (t >= 22);
      @(negedge clk);
      check_eq("t3_go",   32'(a_go), 32'd0);
      check_eq("t3_mar",  32'(a_mar), 32'(t >= 1 && t <= 16));
      check_eq("t3_mdri", 32'(a_mdri), 32'(t >= 23 && t <= 38));
      check_eq("t3_sd",   32'(a_sd), 32'(t == 16 || t == 38));
      check_eq("t3_pc",   32'(a_pc), 32'(t == 39));
      check_eq("t3_cmd",  32'(a_cmd), (t == 0) ? 32'd0 : (t <= 38) ? 32'd2 : 32'd1);
    end

    // 4: store (is_load also high) with a 5-cycle stall at data beat 7
    do_reset();
    run_fetch();
    n_mdro = 0;
    for (int t = 0; t < 44; t++) begin
      step();
      done = (t == 0); is_store = (t == 0); is_load = (t == 0);
      rr = !(t >= 24 && t <= 28); dr = (t >= 42);
      @(negedge clk);
      if (a_mdro) n_mdro++;
      check_eq("t4_mar",  32'(a_mar), 32'(t >= 1 && t <= 16));
      check_eq("t4_mdro", 32'(a_mdro), 32'((t >= 17 && t <= 23) || (t >= 29 && t <= 37)));
      check_eq("t4_sd",   32'(a_sd), 32'(t == 16 || t == 37));
      check_eq("t4_pc",   32'(a_pc), 32'(t == 43));
      check_eq("t4_mdri", 32'(a_mdri), 32'd0);
      check_eq("t4_cmd",  32'(a_cmd), (t == 0) ? 32'd0 : (t <= 42) ? 32'd3 : 32'd1);
    end
    check_eq("t4_mdro_total", 32'(n_mdro), 32'd16);

    // 5: reset pulse right after load data beat 7
    do_reset();
    run_fetch();
    for (int t = 0; t < 45; t++) begin
      step();
      done = (t == 0); is_load = (t == 0); rr = 1'b1; dr = 1'b1; rst = (t == 26);
      @(negedge clk);
      check_eq("t5_mar",  32'(a_mar), 32'(t >= 1 && t <= 16));
      check_eq("t5_mdri", 32'(a_mdri), 32'(t >= 18 && t <= 25));
      check_eq("t5_sd",   32'(a_sd), 32'(t == 16 || t == 42));
      check_eq("t5_pc",   32'(a_pc), 32'(t >= 27 && t <= 42));
      check_eq("t5_ir",   32'(a_ir), 32'(t == 44));
      check_eq("t5_cmd",  32'(a_cmd), (t == 0 || t == 26) ? 32'd0 : (t <= 25) ? 32'd2 : 32'd1);
      if (t == 26) check_eq("t5_rst_all", 32'(a_all), 32'd0);
    end

    // 6: response never arrives
    do_reset();
    for (int t = 0; t < 36; t++) begin
      step();
      rst = 1'b0; rr = 1'b1; dr = 1'b0;
      @(negedge clk);
      check_eq("t6_cmd", 32'(a_cmd), 32'd1);
      check_eq("t6_ir",  32'(a_ir), 32'd0);
`ifdef SERIAL_MEM_SEQ_TIMEOUT_EN
      check_eq("t6_pc",  32'(a_pc), 32'(t <= 15 || t >= 24));
      check_eq("t6_err", 32'(a_err), 32'(t == 23));
`else
      check_eq("t6_pc",  32'(a_pc), 32'(t <= 15));
      check_eq("t6_err", 32'(a_err), 32'd0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
